// File: rtl/serpent_pkg.sv
// ============================================================================
// Module   : serpent_pkg
// Purpose  : Shared Serpent constants, inverse S-boxes, IP/FP bit permutations
// Revision : 1.0
// ============================================================================
`default_nettype none

package serpent_pkg;

  localparam int ROUNDS      = 32;
  localparam int SUBKEY_LAST = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Each 64-bit table holds entry x in bits [4x+3:4x]; InvS7 is the top word.
  localparam logic [511:0] INV_SBOX = {
    64'h241A_7BC5_8FE9_D603,
    64'hB8C2_7E94_0635_D1AF,
    64'h0AC7_356B_ED14_92F8,
    64'h1DF4_6BC2_E79A_3805,
    64'h1F84_2C53_D6EB_7A90,
    64'h7A85_D630_21EB_4F9C,
    64'h0AD1_974B_3C6F_E285,
    64'h289F_74E1_C56A_0B3D
  };

  function automatic logic [3:0] inv_sbox(input logic [2:0] box, input logic [3:0] x);
    return INV_SBOX[{box, x, 2'b00} +: 4];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Output bit i takes input bit (i%4)*32 + i/4.
  function automatic logic [127:0] initial_permutation(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 128; i++) begin
      y[i] = x[{i[1:0], i[6:2]}];
    end
    return y;
  endfunction

  // Output bit i takes input bit (i%32)*4 + i/32; inverse of the IP.
  function automatic logic [127:0] final_permutation(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 128; i++) begin
      y[i] = x[{i[4:0], i[6:5]}];
    end
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serpent_de_round.sv
// ============================================================================
// Module   : serpent_de_round
// Purpose  : One combinational inverse Serpent round in the IP domain
// Revision : 1.0
// ============================================================================
`default_nettype none

module serpent_de_round
  import serpent_pkg::*;
(
  input  logic [127:0] i_data,
  input  logic [5:0]   i_round,
  input  logic [127:0] i_subkey,
  output logic [127:0] o_data
);

  logic [31:0]  w_x0, w_x1, w_x2, w_x3;
  logic [127:0] w_lt;
  logic [127:0] w_sout;

  // The linear transform works on 32-bit words; FP regroups the IP-domain
  // nibbles into those words and IP puts them back.
  always_comb begin
    {w_x3, w_x2, w_x1, w_x0} = final_permutation(i_data);
    w_x2 = rotr32(w_x2, 22);
    w_x0 = rotr32(w_x0, 5);
    w_x2 = w_x2 ^ w_x3 ^ (w_x1 << 7);
    w_x0 = w_x0 ^ w_x1 ^ w_x3;
    w_x3 = rotr32(w_x3, 7);
    w_x1 = rotr32(w_x1, 1);
    w_x3 = w_x3 ^ w_x2 ^ (w_x0 << 3);
    w_x1 = w_x1 ^ w_x0 ^ w_x2;
    w_x2 = rotr32(w_x2, 3);
    w_x0 = rotr32(w_x0, 13);
    if (i_round == 6'(ROUNDS - 1)) begin
      w_lt = i_data;
    end else begin
      w_lt = initial_permutation({w_x3, w_x2, w_x1, w_x0});
    end
  end

  for (genvar gi = 0; gi < 32; gi++) begin : g_sbox
    assign w_sout[4*gi +: 4] = inv_sbox(i_round[2:0], w_lt[4*gi +: 4]);
  end

  assign o_data = w_sout ^ i_subkey;

endmodule

`default_nettype wire

// File: rtl/serpent_de.sv
// ============================================================================
// Module   : serpent_de
// Purpose  : Iterative Serpent decryption, one inverse round per clock
// Revision : 1.0
// ============================================================================
`default_nettype none

module serpent_de
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_subkey_valid,
  input  logic [127:0] i_key,
  input  logic [127:0] i_data,
  output logic [127:0] o_data,
  output logic [5:0]   o_address,
  output logic         o_data_valid,
  output logic         o_busy
);

  state_t       r_state, w_state_nx;
  logic [5:0]   r_round, w_round_nx;
  logic [127:0] r_data, w_data_nx;
  logic [127:0] r_out, w_out_nx;
  logic         r_valid, w_valid_nx;
  logic [127:0] w_rnd;

  serpent_de_round u_round (
    .i_data   (r_data),
    .i_round  (r_round),
    .i_subkey (i_key),
    .o_data   (w_rnd)
  );

  always_comb begin
    w_state_nx = r_state;
    w_round_nx = r_round;
    w_data_nx  = r_data;
    w_out_nx   = r_out;
    w_valid_nx = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en && i_subkey_valid) begin
          w_data_nx  = initial_permutation(i_data) ^ i_key;
          w_round_nx = 6'(ROUNDS - 1);
          w_state_nx = ST_ROUND;
        end
      end
      ST_ROUND: begin
        // A missing subkey simply freezes everything for that cycle.
        if (i_subkey_valid) begin
          w_data_nx = w_rnd;
          if (r_round == 6'd0) begin
            w_out_nx   = final_permutation(w_rnd);
            w_valid_nx = 1'b1;
            w_state_nx = ST_DONE;
          end else begin
            w_round_nx = r_round - 6'd1;
          end
        end
      end
      ST_DONE: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_round <= 6'd0;
      r_data  <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_round <= w_round_nx;
      r_data  <= w_data_nx;
      r_out   <= w_out_nx;
      r_valid <= w_valid_nx;
    end
  end

  assign o_address    = (r_state == ST_IDLE) ? 6'(SUBKEY_LAST) : r_round;
  assign o_data       = r_out;
  assign o_data_valid = r_valid;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/serpent_de.md
# serpent_de

Iterative Serpent block-decryption core, the inverse of the encryption core in the `serpent_xts` datapath. It takes one 128-bit ciphertext block and pulls subkeys K32 down to K0 from the shared key-schedule store through an address/data port. It runs one inverse round per clock and returns the plaintext with a one-cycle valid pulse. The XTS decrypt path instantiates it in place of the encryption core.

## Interface
- No parameters. Round count (32) and subkey count (33) are package constants.
- `i_clk` in 1: single clock; all logic on rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_en` in 1: start request; sampled only in IDLE.
- `i_subkey_valid` in 1: key-schedule store ready; gates start and every round step.
- `i_key` in 128: subkey addressed by `o_address`, valid combinationally in the same cycle.
- `i_data` in 128: ciphertext block; sampled on the start cycle only.
- `o_data` out 128: plaintext, registered; holds until the next completion.
- `o_address` out 6: subkey index requested (32..0).
- `o_data_valid` out 1: one-cycle pulse when `o_data` is updated.
- `o_busy` out 1: high in ROUND and DONE.

## Operation
- Algorithm:
  - X = IP(C) ^ K32.
  - B = InvS31(X) ^ K31.
  - For r = 30 down to 0: B = InvS_{r mod 8}(InvLT(B)) ^ K_r.
  - P = FP(B).
- States (2-bit): IDLE, ROUND, DONE.
- IDLE:
  - `o_address` = 32.
  - On `i_en && i_subkey_valid`: `data` <= IP(`i_data`) ^ `i_key`, round <= 31, go to ROUND.
  - Otherwise hold.
- ROUND:
  - `o_address` = round.
  - If `i_subkey_valid`: `data` <= inv_round(`data`, round) ^ `i_key`.
  - inv_round skips InvLT when round == 31.
  - If round == 0, load `o_data` <= FP(inv_round(`data`, 0) ^ `i_key`), set `o_data_valid`, and go to DONE. Otherwise round <= round − 1.
  - If `!i_subkey_valid`: freeze `data`, round and `o_address`; no progress.
- DONE:
  - `o_data_valid` drops.
  - Go to IDLE unconditionally; no start is accepted in DONE.
- Round counter is 6-bit and never wraps below 0; the exit is decided on round == 0.
- `i_en` and `i_data` are ignored outside IDLE. Deasserting `i_en` mid-block does not abort.
- Reset at any time: state IDLE, round 0, `data` 0, `o_data` 0, `o_data_valid` 0, `o_address` 32, `o_busy` 0. A partial block is discarded with no valid pulse.

## Timing
- Start accepted at the edge ending cycle T.
- ROUND occupies cycles T+1..T+32, with `o_address` 31..0.
- `o_data_valid` is high in cycle T+33 only; `o_data` is stable from T+33 onward.
- Earliest next start is accepted at the edge ending T+34, since IDLE is re-entered in cycle T+34. Throughput is 34 cycles per block without stalls.
- Each low cycle of `i_subkey_valid` during ROUND adds one cycle of latency.
- Reset values of all outputs are as listed under Operation, and are visible the cycle after `i_rst` is sampled high.

## Structure
- Shared package `serpent_pkg`:
  - `ROUNDS` = 32, `SUBKEY_LAST` = 32.
  - State encodings.
  - Inverse S-box tables InvS0..InvS7 (4-bit).
  - IP/FP bit-index functions, reused by the encryption core.
- Sub-module `serpent_de_round`:
  - Inputs `i_data[127:0]`, `i_round[5:0]`, `i_subkey[127:0]`; output `o_data[127:0]`.
  - Purely combinational: conditional InvLT (skipped for round 31), then 32-way InvS_{round mod 8}, then subkey XOR.
- Reuse existing `initial_permutation` and `final_permutation` unchanged.

## Test plan
- Round-trip: zero key, plaintext 128'h0 encrypted by the encryption core, ciphertext fed to serpent_de → `o_data` == 128'h0. `o_data_valid` is high exactly in cycle T+33; `o_address` sequence is 32, 31, …, 0.
- Round-trip with key 128'h000102…0F and plaintext 128'h00112233_44556677_8899AABB_CCDDEEFF → exact plaintext recovered; `o_busy` is high for 33 cycles.
- Stall: drop `i_subkey_valid` for 3 cycles while `o_address` == 17 → address holds at 17, valid arrives at T+36, result unchanged.
- Reset mid-block: assert `i_rst` with `o_address` == 9 → next cycle all outputs at reset values, and no `o_data_valid` ever follows.
- Back-to-back: hold `i_en` high for two blocks → second start accepted at the edge ending T+34, no start taken in DONE, both plaintexts correct.
- Ignored inputs: change `i_data` and toggle `i_en` during ROUND → first result unaffected.
